multicore_pc_sequencer: RTL and testbench
=========================================

Name: multicore_pc_sequencer

Overview:
Parametrised bank of per-core program counters for the parallel multi-core processor. It generalises the four fixed counters used today to NCORES cores, with configurable address width. Each core gets conditional jump, a call/return stack of configurable depth, stall, halt detection and sticky stack-error flags. Each core's PC output drives its address port on the shared instruction RAM; its decoded op, target and condition come back from that core's instruction and data-RAM fetch.

Parameters:
NCORES, 4, number of independent cores/PCs
AW, 16, PC and jump-target width in bits
STACK_DEPTH, 4, return-stack entries per core (>=1)
INIT_BASE, 0, reset PC of core 0
PC_STRIDE, 6, reset PC of core i = INIT_BASE + i*PC_STRIDE (mod 2^AW)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; dominates all other inputs
run  input  NCORES  per-core advance enable; 0 = core stalls
op  input  2*NCORES  per-core op, core i at [2i+1:2i]: 00 NEXT, 01 JUMP, 10 CALL, 11 RET
cond  input  NCORES  per-core jump condition, used by JUMP only
jump_target  input  AW*NCORES  per-core target, core i at [AW*i+AW-1:AW*i]
pc  output  AW*NCORES  registered PC per core, same packing as jump_target
stack_level  output  SW*NCORES  entries in use per core, SW = clog2(STACK_DEPTH+1)
halted  output  NCORES  sticky halt flag per core
stack_ovf  output  NCORES  sticky: CALL attempted with stack full
stack_unf  output  NCORES  sticky: RET attempted with stack empty

Behaviour:
- Reset (synchronous):
  - pc[i] = INIT_BASE + i*PC_STRIDE, truncated to AW.
  - stack_level, halted, stack_ovf, stack_unf all 0.
  - Stack RAM contents are not cleared; they are don't-care.
- Cores are fully independent. No shared state and no cross-core arbitration. Simultaneous ops on different cores never interact.
- All outputs are registered. An op sampled at edge k is reflected on pc/flags after edge k (1-cycle latency).
- Core i is frozen (pc, stack, flags hold) when run[i]=0 or halted[i]=1.
- When core i is active (run=1, halted=0):
  - NEXT: pc <= pc+1, mod 2^AW (0xFFFF -> 0x0000 at AW=16).
  - JUMP, cond=1: pc <= target. If target == current pc, also halted <= 1; pc stays unchanged.
  - JUMP, cond=0: pc <= pc+1.
  - CALL, stack not full: push pc+1 (mod 2^AW), stack_level+1, pc <= target. cond is ignored.
  - CALL, stack full (level == STACK_DEPTH): no push, stack_ovf <= 1, pc <= pc+1.
  - RET, stack not empty: pc <= top entry, stack_level-1.
  - RET, stack empty: stack_unf <= 1, pc <= pc+1, level stays 0.
- Stack is LIFO. The entry pushed last is returned first.
- Error and halt flags are sticky. Only reset clears them.
- Flags do not stall the core, except halted, which freezes it.
- Reset asserted mid-CALL/RET or while stalled restores the reset state on that edge. No partial push or pop is retained.
- Op encoding 11 with cond is RET; cond is ignored.
- Generate-loop implementation per core. No combinational path from inputs to outputs.

Test Plan:
- Reset with defaults -> pc = {0x12,0x0C,0x06,0x00} (core3..core0); all flags 0; stack_level 0.
- Core0 NEXT x3, then JUMP cond=0, then JUMP cond=1 target 0x40 -> pc0 sequence 1,2,3,4,0x40. Core1 run=0 throughout -> pc1 holds 0x06.
- Core2: CALL 0x100, CALL 0x200, RET, RET from pc 0x0C -> pc2 sequence 0x100, 0x200, 0x101, 0x0D; stack_level 1,2,1,0.
- Core3, STACK_DEPTH=4: five CALLs to 0x80 -> 5th call sets stack_ovf3, pc3 = 0x81, level stays 4. Then RET on an emptied stack -> stack_unf3=1, pc+1.
- Core0 at pc 0x40, JUMP cond=1 target 0x40 -> halted0=1. NEXT with run=1 afterwards -> pc0 stays 0x40. Reset -> pc0=0, halted0=0.
- AW=16 core at 0xFFFF, NEXT -> 0x0000. CALL at 0xFFFF -> pushed return 0x0000; RET -> pc 0x0000. Reset asserted same cycle as a CALL -> level 0, pc = reset value.

Source files
------------

// File: rtl/multicore_pc_sequencer.sv
// Bank of independent per-core program counters with conditional jump, a call/return stack,
// stall, halt detection and sticky stack-error flags. All outputs are registered.
module multicore_pc_sequencer #(
    parameter int unsigned NCORES      = 4,
    parameter int unsigned AW          = 16,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned INIT_BASE   = 0,
    parameter int unsigned PC_STRIDE   = 6,
    localparam int unsigned SW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NCORES-1:0]    i_run,
    input  logic [2*NCORES-1:0]  i_op,
    input  logic [NCORES-1:0]    i_cond,
    input  logic [AW*NCORES-1:0] i_jump_target,
    output logic [AW*NCORES-1:0] o_pc,
    output logic [SW*NCORES-1:0] o_stack_level,
    output logic [NCORES-1:0]    o_halted,
    output logic [NCORES-1:0]    o_stack_ovf,
    output logic [NCORES-1:0]    o_stack_unf
);

    typedef enum logic [1:0] {OpNext, OpJump, OpCall, OpRet} op_e;

    // Stack index width; a depth of one still needs a one-bit index.
    localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    for (genvar g = 0; g < NCORES; g++) begin : g_core
        localparam logic [AW-1:0] RESET_PC = AW'(INIT_BASE + g * PC_STRIDE);

        logic [AW-1:0] r_pc;
        logic [SW-1:0] r_level;
        logic          r_halted;
        logic          r_ovf;
        logic          r_unf;
        logic [AW-1:0] r_stack [2**IW];

        op_e           w_op;
        logic [AW-1:0] w_target;
        logic [AW-1:0] w_pc_inc;
        logic [IW-1:0] w_push_idx;
        logic [IW-1:0] w_pop_idx;
        logic          w_full;
        logic          w_empty;

        assign w_op       = op_e'(i_op[2*g +: 2]);
        assign w_target   = i_jump_target[AW*g +: AW];
        assign w_pc_inc   = r_pc + AW'(1);
        assign w_push_idx = IW'(r_level);
        assign w_pop_idx  = IW'(r_level - SW'(1));
        assign w_full     = (r_level == SW'(STACK_DEPTH));
        assign w_empty    = (r_level == '0);

        // Stack entries are deliberately left out of reset; only the level is cleared.
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_pc     <= RESET_PC;
                r_level  <= '0;
                r_halted <= 1'b0;
                r_ovf    <= 1'b0;
                r_unf    <= 1'b0;
            end else if (i_run[g] && !r_halted) begin
                unique case (w_op)
                    OpNext: r_pc <= w_pc_inc;
                    OpJump: begin
                        if (i_cond[g]) begin
                            r_pc <= w_target;
                            if (w_target == r_pc) r_halted <= 1'b1;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                    OpCall: begin
                        if (w_full) begin
                            r_ovf <= 1'b1;
                            r_pc  <= w_pc_inc;
                        end else begin
                            r_stack[w_push_idx] <= w_pc_inc;
                            r_level             <= r_level + SW'(1);
                            r_pc                <= w_target;
                        end
                    end
                    OpRet: begin
                        if (w_empty) begin
                            r_unf <= 1'b1;
                            r_pc  <= w_pc_inc;
                        end else begin
                            r_pc    <= r_stack[w_pop_idx];
                            r_level <= r_level - SW'(1);
                        end
                    end
                endcase
            end
        end

        assign o_pc[AW*g +: AW]          = r_pc;
        assign o_stack_level[SW*g +: SW] = r_level;
        assign o_halted[g]               = r_halted;
        assign o_stack_ovf[g]            = r_ovf;
        assign o_stack_unf[g]            = r_unf;
    end

endmodule

// File: tb/tb_multicore_pc_sequencer.sv
// Scoreboard bench: the driver updates a queue-based reference model and pushes the expected
// state; a separate monitor pops and compares after every rising edge.
module tb_multicore_pc_sequencer;

    localparam int unsigned NC    = 4;
    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned BASE  = 0;
    localparam int unsigned STR   = 6;
    localparam int unsigned SW    = $clog2(DEPTH + 1);
    localparam int unsigned MASK  = (1 << AW) - 1;

    localparam logic [1:0] NEXT = 2'b00, JUMP = 2'b01, CALL = 2'b10, RET = 2'b11;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NC-1:0]        run;
    logic [2*NC-1:0]      op;
    logic [NC-1:0]        cond;
    logic [AW*NC-1:0]     tgt;
    logic [AW*NC-1:0]     pc;
    logic [SW*NC-1:0]     lvl;
    logic [NC-1:0]        halted, ovf, unf;

    multicore_pc_sequencer #(
        .NCORES(NC), .AW(AW), .STACK_DEPTH(DEPTH), .INIT_BASE(BASE), .PC_STRIDE(STR)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_run(run), .i_op(op), .i_cond(cond),
        .i_jump_target(tgt), .o_pc(pc), .o_stack_level(lvl), .o_halted(halted),
        .o_stack_ovf(ovf), .o_stack_unf(unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned pc [NC];
        int unsigned lvl [NC];
        bit          h [NC];
        bit          o [NC];
        bit          u [NC];
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: plain integers and a queue per core as the return stack.
    int unsigned m_pc [NC];
    int unsigned m_stk [NC][$];
    bit          m_h [NC], m_o [NC], m_u [NC];

    task automatic model_step(input bit rst, input logic [NC-1:0] r, input logic [2*NC-1:0] o,
                              input logic [NC-1:0] c, input logic [AW*NC-1:0] t);
        for (int i = 0; i < NC; i++) begin
            int unsigned cur, nxt, tg;
            cur = m_pc[i];
            nxt = (cur + 1) & MASK;
            tg  = int'(t[AW*i +: AW]);
            if (rst) begin
                m_pc[i] = (BASE + i * STR) & MASK;
                m_stk[i].delete();
                m_h[i] = 0; m_o[i] = 0; m_u[i] = 0;
            end else if (r[i] && !m_h[i]) begin
                case (o[2*i +: 2])
                    NEXT: m_pc[i] = nxt;
                    JUMP: begin
                        if (c[i]) begin
                            if (tg == cur) m_h[i] = 1;
                            m_pc[i] = tg;
                        end else m_pc[i] = nxt;
                    end
                    CALL: begin
                        if (m_stk[i].size() >= DEPTH) begin
                            m_o[i] = 1; m_pc[i] = nxt;
                        end else begin
                            m_stk[i].push_back(nxt); m_pc[i] = tg;
                        end
                    end
                    default: begin
                        if (m_stk[i].size() == 0) begin
                            m_u[i] = 1; m_pc[i] = nxt;
                        end else m_pc[i] = m_stk[i].pop_back();
                    end
                endcase
            end
        end
    endtask

    task automatic step(input bit rst, input logic [NC-1:0] r, input logic [2*NC-1:0] o,
                        input logic [NC-1:0] c, input logic [AW*NC-1:0] t);
        exp_t e;
        @(negedge clk);
        reset = rst; run = r; op = o; cond = c; tgt = t;
        model_step(rst, r, o, c, t);
        for (int i = 0; i < NC; i++) begin
            e.pc[i] = m_pc[i]; e.lvl[i] = m_stk[i].size();
            e.h[i] = m_h[i]; e.o[i] = m_o[i]; e.u[i] = m_u[i];
        end
        sb.push_back(e);
    endtask

    // Run a single core with the given op; all other cores stalled.
    task automatic one(input int core, input logic [1:0] o, input bit c, input int unsigned t);
        logic [NC-1:0]    r  = '0;
        logic [2*NC-1:0]  ov = '0;
        logic [NC-1:0]    cv = '0;
        logic [AW*NC-1:0] tv = '0;
        r[core] = 1'b1;
        ov[2*core +: 2] = o;
        cv[core] = c;
        tv[AW*core +: AW] = AW'(t);
        step(0, r, ov, cv, tv);
    endtask

    task automatic chk(input string name, input int core, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s core%0d: got 0x%0h expected 0x%0h at %0t", name, core, act, exp,
                     $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                for (int i = 0; i < NC; i++) begin
                    chk("pc", i, 32'(pc[AW*i +: AW]), e.pc[i]);
                    chk("stack_level", i, 32'(lvl[SW*i +: SW]), e.lvl[i]);
                    chk("flags(h,ovf,unf)", i, {29'd0, halted[i], ovf[i], unf[i]},
                        {29'd0, e.h[i], e.o[i], e.u[i]});
                end
            end
        end
    end

    initial begin : driver
        reset = 1'b0; run = '0; op = '0; cond = '0; tgt = '0;
        step(1, '0, '0, '0, '0);
        step(0, '0, '0, '0, '0);

        repeat (3) one(0, NEXT, 0, 0);
        one(0, JUMP, 0, 16'h0040);
        one(0, JUMP, 1, 16'h0040);

        one(2, CALL, 1, 16'h0100);
        one(2, CALL, 0, 16'h0200);
        one(2, RET, 1, 0);
        one(2, RET, 0, 0);

        repeat (5) one(3, CALL, 0, 16'h0080);
        repeat (5) one(3, RET, 0, 0);

        one(0, JUMP, 1, 16'h0040);
        one(0, NEXT, 0, 0);
        step(0, '1, '0, '0, '0);

        one(1, JUMP, 1, 16'hFFFF);
        one(1, NEXT, 0, 0);
        one(1, JUMP, 1, 16'hFFFF);
        one(1, CALL, 0, 16'h0010);
        one(1, RET, 0, 0);

        step(1, '1, {NC{CALL}}, '1, '1);
        step(0, '0, '0, '0, '0);

        for (int n = 0; n < 3000; n++) begin
            logic [NC-1:0]    r;
            logic [2*NC-1:0]  o;
            logic [NC-1:0]    c;
            logic [AW*NC-1:0] t;
            for (int i = 0; i < NC; i++) begin
                int unsigned sel;
                r[i] = ($urandom_range(0, 5) != 0);
                o[2*i +: 2] = 2'($urandom);
                c[i] = 1'($urandom);
                sel = $urandom_range(0, 15);
                if (sel == 0) t[AW*i +: AW] = AW'(m_pc[i]);
                else if (sel == 1) t[AW*i +: AW] = '1;
                else t[AW*i +: AW] = AW'($urandom);
            end
            step(($urandom_range(0, 39) == 0), r, o, c, t);
        end

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
